// File: rtl/inlet_seq_pkg.sv
// rtl/inlet_seq_pkg.sv - shared state encoding and counter sizing for the inlet dose sequencer (INLET_FLUSH_EN adds the FLUSH state)
`timescale 1ns/1ps

package inlet_seq_pkg;

    // Sequencer states; FLUSH exists only when the buffer flush is compiled in
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_PUMP   = 3'd2,
`ifdef INLET_FLUSH_EN
        S_FLUSH  = 3'd3,
`endif
        S_HOLD   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

`ifdef INLET_FLUSH_EN
    localparam int STATE_CNT = 6;
`else
    localparam int STATE_CNT = 5;
`endif

    // Settle and transit share one counter; it must reach the larger of the two
    localparam int SETTLE_CYC_DEF  = 32;
    localparam int TRANSIT_CYC_DEF = 256;

    function automatic int cyc_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

    localparam int SEQ_CYC_W = cyc_width(SETTLE_CYC_DEF, TRANSIT_CYC_DEF);

    typedef logic [SEQ_CYC_W-1:0] seq_cyc_t;

endpackage

// File: rtl/inlet_dose_sequencer_step_timer.sv
// rtl/inlet_dose_sequencer_step_timer.sv - pump step period counter with first-cycle pulse and end-of-period strobe
`timescale 1ns/1ps

module step_timer #(
    parameter int STEP_PERIOD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic first,
    output logic last
);

    localparam int CNT_W = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running period count while enabled; wraps so PUMP->FLUSH starts a fresh period
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign first = en && (cnt == '0);
    assign last  = en && (cnt == CNT_LAST);

endmodule

// File: rtl/inlet_dose_sequencer.sv
// rtl/inlet_dose_sequencer.sv - inlet valve/pump dose sequencer; define INLET_FLUSH_EN to add a buffer flush after pumping
`timescale 1ns/1ps

module inlet_dose_sequencer
    import inlet_seq_pkg::*;
#(
    parameter int VOL_W       = 16,
    parameter int STEP_PERIOD = 8,
    parameter int SETTLE_CYC  = 32,
    parameter int TRANSIT_CYC = 256,
    parameter int FLUSH_STEPS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [VOL_W-1:0] req_vol,
    input  logic             abort,
    output logic             valve_open,
    output logic             pump_step,
    output logic             flush_sel,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [VOL_W-1:0] steps_done
);

    state_t           state;
    state_t           state_nxt;
    logic [VOL_W-1:0] vol_q;
    logic [VOL_W-1:0] steps_q;
    seq_cyc_t         seq_cnt;
    logic             aborted_q;
    logic             active;
    logic             step_en;
    logic             step_en_nxt;
    logic             step_first;
    logic             step_last;
    logic             settle_end;
    logic             hold_end;
    logic             pump_end;
    logic             pump_pulse;

    assign active      = (state != S_IDLE) && (state != S_DONE);
    assign settle_end  = (seq_cnt == seq_cyc_t'(SETTLE_CYC - 1));
    assign hold_end    = (seq_cnt == seq_cyc_t'(TRANSIT_CYC - 1));
    assign pump_end    = step_last && (steps_q == vol_q);
    assign pump_pulse  = (state == S_PUMP) && step_first;

`ifdef INLET_FLUSH_EN
    localparam int FL_W = $clog2(FLUSH_STEPS + 1);

    logic [FL_W-1:0] flush_cnt;
    logic            flush_end;

    assign step_en     = (state == S_PUMP) || (state == S_FLUSH);
    assign step_en_nxt = (state_nxt == S_PUMP) || (state_nxt == S_FLUSH);
    assign flush_end   = step_last && (flush_cnt == FL_W'(FLUSH_STEPS));
    assign flush_sel   = (state == S_FLUSH);

    // Counts buffer flush steps; restarts on every FLUSH entry
    always_ff @(posedge clk) begin
        if (!rst_n || state != S_FLUSH) begin
            flush_cnt <= '0;
        end else if (step_first) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign step_en     = (state == S_PUMP);
    assign step_en_nxt = (state_nxt == S_PUMP);
    assign flush_sel   = 1'b0;
`endif

    step_timer #(
        .STEP_PERIOD (STEP_PERIOD)
    ) u_step_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (step_en),
        .clr   (step_en && !step_en_nxt),
        .first (step_first),
        .last  (step_last)
    );

    // Next-state decode; abort overrides every in-progress transition
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_valid) state_nxt = (req_vol == '0) ? S_DONE : S_SETTLE;
            S_SETTLE: if (settle_end) state_nxt = S_PUMP;
`ifdef INLET_FLUSH_EN
            S_PUMP:   if (pump_end) state_nxt = S_FLUSH;
            S_FLUSH:  if (flush_end) state_nxt = S_HOLD;
`else
            S_PUMP:   if (pump_end) state_nxt = S_HOLD;
`endif
            S_HOLD:   if (hold_end) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (active && abort) begin
            state_nxt = S_DONE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shared settle/transit cycle counter, zeroed on every state change
    always_ff @(posedge clk) begin
        if (!rst_n || state_nxt != state) begin
            seq_cnt <= '0;
        end else if (state == S_SETTLE || state == S_HOLD) begin
            seq_cnt <= seq_cnt + 1'b1;
        end
    end

    // Dose bookkeeping: latched volume, issued sample steps, abort flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vol_q     <= '0;
            steps_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                vol_q     <= req_vol;
                steps_q   <= '0;
                aborted_q <= 1'b0;
            end
            if (pump_pulse) begin
                steps_q <= steps_q + 1'b1;
            end
            if (active && abort) begin
                aborted_q <= 1'b1;
            end
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign valve_open = (state == S_SETTLE) || step_en;
    assign pump_step  = step_en && step_first;
    assign done       = (state == S_DONE);
    assign aborted    = (state == S_DONE) && aborted_q;
    // The pulse cycle already shows the incremented count
    assign steps_done = steps_q + {{(VOL_W-1){1'b0}}, pump_pulse};

endmodule

// File: tb/tb_inlet_dose_sequencer.sv
// tb/tb_inlet_dose_sequencer.sv - directed self-checking bench for inlet_dose_sequencer
`timescale 1ns/1ps

module tb_inlet_dose_sequencer;

    localparam int VOL_W = 16;
    localparam int SP    = 8;
    localparam int SC    = 32;
    localparam int TC    = 256;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [VOL_W-1:0] req_vol;
    logic             abort;
    logic             valve_open;
    logic             pump_step;
    logic             flush_sel;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [VOL_W-1:0] steps_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    inlet_dose_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_vol    (req_vol),
        .abort      (abort),
        .valve_open (valve_open),
        .pump_step  (pump_step),
        .flush_sel  (flush_sel),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_done (steps_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".req_ready"},  32'(req_ready),  32'd1);
        chk({tag, ".busy"},       32'(busy),       32'd0);
        chk({tag, ".valve_open"}, 32'(valve_open), 32'd0);
        chk({tag, ".pump_step"},  32'(pump_step),  32'd0);
        chk({tag, ".flush_sel"},  32'(flush_sel),  32'd0);
        chk({tag, ".done"},       32'(done),       32'd0);
        chk({tag, ".aborted"},    32'(aborted),    32'd0);
    endtask

    // Accept a dose in cycle 0 and check every cycle through the one after done.
    // abort_at < 1 means no abort while busy (abort_at == 0 drives abort with the request).
    task automatic dose(input int n, input int abort_at, input string tag);
        int hold_c;
        int done_c;
        int ab;
        int pulses;
        bit exp_pulse;
        bit exp_valve;
        bit exp_done;
        hold_c = 1 + SC + n * SP;
        ab     = (n > 0 && abort_at >= 1 && abort_at < hold_c + TC) ? abort_at : -1;
        done_c = (n == 0) ? 1 : ((ab > 0) ? ab + 1 : hold_c + TC);
        req_valid = 1'b1;
        req_vol   = VOL_W'(n);
        abort     = (abort_at == 0);
        chk({tag, ".accept_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_vol   = '0;
        abort     = 1'b0;
        pulses    = 0;
        for (int c = 1; c <= done_c; c++) begin
            exp_pulse = (n > 0) && (c >= 1 + SC) && (c < hold_c) &&
                        (((c - 1 - SC) % SP) == 0) && (ab < 0 || c <= ab);
            if (exp_pulse) pulses++;
            exp_valve = (n > 0) && (c < hold_c) && (c < done_c);
            exp_done  = (c == done_c);
            chk($sformatf("%s.valve@%0d", tag, c),   32'(valve_open), 32'(exp_valve));
            chk($sformatf("%s.pump@%0d", tag, c),    32'(pump_step),  32'(exp_pulse));
            chk($sformatf("%s.done@%0d", tag, c),    32'(done),       32'(exp_done));
            chk($sformatf("%s.aborted@%0d", tag, c), 32'(aborted),    32'(exp_done && ab > 0));
            chk($sformatf("%s.busy@%0d", tag, c),    32'(busy),       32'd1);
            chk($sformatf("%s.ready@%0d", tag, c),   32'(req_ready),  32'd0);
            chk($sformatf("%s.flush@%0d", tag, c),   32'(flush_sel),  32'd0);
            chk($sformatf("%s.steps@%0d", tag, c),   32'(steps_done), 32'(pulses));
            if (c == ab) abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        check_idle({tag, ".after"});
        chk({tag, ".final_steps"}, 32'(steps_done), 32'(pulses));
    endtask

    initial begin
        int cnt;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_vol   = '0;
        abort     = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check_idle("reset");
        chk("reset.steps_done", 32'(steps_done), 32'd0);

        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (pump_step || busy || valve_open) cnt++;
        end
        chk("idle100.activity", 32'(cnt), 32'd0);

        dose(3, -1, "n3");
        dose(0, -1, "n0");
        dose(5, 45, "n5_abort45");

        abort = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy || done) cnt++;
        end
        abort = 1'b0;
        chk("idle_abort.activity", 32'(cnt), 32'd0);
        check_idle("idle_abort");

        dose(1, 0, "n1_abort_on_accept");
        dose(2, 10, "settle_abort");
        dose(3, 41, "abort_on_pulse");
        dose(1, 100, "hold_abort");

        req_valid = 1'b1;
        req_vol   = VOL_W'(4);
        tick();
        req_valid = 1'b0;
        req_vol   = '0;
        repeat (39) tick();
        chk("rst_mid.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check_idle("rst_mid");
        chk("rst_mid.steps_done", 32'(steps_done), 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (done || busy) cnt++;
            tick();
        end
        chk("rst_mid.no_done", 32'(cnt), 32'd0);
        dose(1, -1, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
